div_sequencer: RTL and testbench
================================

# div_sequencer

Multicycle integer divide unit for the pipelined RV32M core: recognises DIV/DIVU/REM/REMU in the EX stage, captures operands, runs a radix-2 restoring shift-subtract divider over WIDTH iterations and holds the pipeline until the result is ready. It replaces the fixed-length divide stall with a data-dependent controller. Special cases take a fast path, and the unit responds to pipeline flush. It sits beside the EX-stage ALU, drives the hazard unit's stall input and provides the EX result mux with a one-cycle result strobe.

## Interface
- WIDTH, 32: operand/result width; also the iteration count.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- AluControlPort  input  5  EX-stage ALU control.
  - Divide op when bit4 & bit2.
  - Bits[1:0] select 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- op_valid  input  1  EX-stage instruction valid (not a bubble).
- flush  input  1  EX-stage kill (branch mispredict/trap); synchronous.
- rs1_val  input  WIDTH  dividend.
- rs2_val  input  WIDTH  divisor.
- rd_in  input  5  destination register of the EX instruction.
- DivStalled  output  1  combinational; holds IF/ID/EX while the divide is in progress.
- div_result_valid  output  1  registered; one-cycle result strobe.
- div_result  output  WIDTH  quotient or remainder; valid with strobe.
- div_rd  output  5  captured destination register; valid with strobe.

## Operation
- FSM states: IDLE, CALC, DONE.
- Start condition: IDLE & op_valid & isDiv & !flush.
  - On start, latch op[1:0], rd_in, |rs1_val|, |rs2_val| (absolute values only for signed ops), quotient sign and remainder sign.
  - Quotient sign = rs1[MSB] ^ rs2[MSB] for DIV; 0 otherwise.
  - Remainder sign = rs1[MSB] for REM; 0 otherwise.
- Fast path, decided at start; go directly to DONE:
  - Divisor == 0: quotient = all ones; remainder = dividend (raw rs1_val).
  - Signed overflow (DIV/REM, rs1 = 100…0, rs2 = all ones): quotient = rs1_val; remainder = 0.
- Normal path, state CALC:
  - Iteration counter runs from WIDTH-1 down to 0.
  - Each cycle: shift {rem, quo} left by 1; trial = rem[WIDTH:0] − divisor (WIDTH+1 bits).
  - If trial is non-negative, rem = trial and quo[0] = 1.
  - After the counter-0 iteration, apply sign correction and go to DONE.
  - Sign correction uses two's-complement negation of quotient/remainder per the latched signs.
- DONE:
  - div_result_valid = 1.
  - div_result = quotient for op[1] = 0, remainder for op[1] = 1.
  - Unconditional transition to IDLE.
  - No start in DONE, even though the same divide is still visible in EX.
- DivStalled = (state == CALC) | start condition. It is 0 in IDLE without start and 0 in DONE.
- flush in any state: next state IDLE, no strobe, latched values discarded. flush has priority over start.
- reset: state IDLE; div_result_valid, div_result, div_rd and counter all 0.

## Timing
- Cycle T: start; DivStalled = 1.
- Normal divide:
  - T+1 .. T+WIDTH: CALC; DivStalled = 1.
  - T+WIDTH+1: DONE; strobe = 1, DivStalled = 0.
  - The pipeline advances on this edge using div_result.
- Fast path: T+1 is DONE. DivStalled is high for exactly 1 cycle (T).
- Stall length: WIDTH+1 cycles (33 for WIDTH = 32) on the normal path, 1 on the fast path.
- Back-to-back divides: the second enters EX in T+WIDTH+2 and starts in that cycle (state IDLE). No lost or duplicate result.
- div_result and div_rd hold their value until the next DONE; only the strobe is single-cycle.
- Non-divide ops, or op_valid = 0: the block stays in IDLE with all outputs 0/hold.
- reset mid-CALC: IDLE on the next edge; no strobe.

## Test plan
- DIVU 100 / 7, then REMU same operands:
  - Strobe after 33 stall cycles; results 14, then 2.
  - Second op starts the cycle after the first DONE.
- Signed values:
  - DIV −7 / 2 → 0xFFFFFFFD (−3).
  - REM −7 / 2 → 0xFFFFFFFF (−1).
  - DIV 7 / −2 → −3.
  - REM 7 / −2 → 1.
- Divide by zero:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DivStalled high 1 cycle; strobe at T+1.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; fast path.
- Flush asserted at CALC cycle 10:
  - IDLE next cycle; no strobe; DivStalled drops.
  - A following DIVU 9 / 3 returns 3 normally.
- reset pulsed mid-CALC:
  - All outputs 0 next cycle.
  - Non-divide AluControlPort values (bit4 or bit2 clear) never assert DivStalled.

Source files
------------

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - EX-stage divide request/response bundle
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       AluControlPort;
  logic             op_valid;
  logic             flush;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [4:0]       rd_in;
  logic             DivStalled;
  logic             div_result_valid;
  logic [WIDTH-1:0] div_result;
  logic [4:0]       div_rd;

  modport master (
    output AluControlPort, op_valid, flush, rs1_val, rs2_val, rd_in,
    input  DivStalled, div_result_valid, div_result, div_rd
  );

  modport slave (
    input  AluControlPort, op_valid, flush, rs1_val, rs2_val, rd_in,
    output DivStalled, div_result_valid, div_result, div_rd
  );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multicycle RV32M restoring divider with fast path and flush
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  div_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, next_state;
  logic             is_div, start, signed_op, div_zero, sgn_ovf;
  logic [1:0]       op_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] divisor_q, rem_q, quo_q;
  logic             q_neg, r_neg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_n, quo_n, quo_fix, rem_fix;

  assign is_div    = bus.AluControlPort[4] & bus.AluControlPort[2];
  assign signed_op = ~bus.AluControlPort[0];
  assign start     = (state == IDLE) & bus.op_valid & is_div & ~bus.flush;
  assign div_zero  = (bus.rs2_val == '0);
  assign sgn_ovf   = signed_op & (bus.rs1_val == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.rs2_val);

  assign abs_a = (signed_op & bus.rs1_val[WIDTH-1]) ? -bus.rs1_val : bus.rs1_val;
  assign abs_b = (signed_op & bus.rs2_val[WIDTH-1]) ? -bus.rs2_val : bus.rs2_val;

  // One restoring step: the partial remainder is always below the divisor,
  // so whichever branch is kept fits back into WIDTH bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_q};
  assign rem_n   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_n   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign quo_fix = q_neg ? -quo_n : quo_n;
  assign rem_fix = r_neg ? -rem_n : rem_n;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state     = state;
    bus.DivStalled = (state == CALC) | start;
    case (state)
      IDLE: if (start) next_state = (div_zero | sgn_ovf) ? DONE : CALC;
      CALC: if (cnt == '0) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (bus.flush) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.div_result_valid <= 1'b0;
      bus.div_result       <= '0;
      bus.div_rd           <= '0;
      cnt                  <= '0;
      op_q                 <= '0;
      rd_q                 <= '0;
      divisor_q            <= '0;
      rem_q                <= '0;
      quo_q                <= '0;
      q_neg                <= 1'b0;
      r_neg                <= 1'b0;
    end else begin
      bus.div_result_valid <= 1'b0;
      if (start) begin
        op_q      <= bus.AluControlPort[1:0];
        rd_q      <= bus.rd_in;
        divisor_q <= abs_b;
        quo_q     <= abs_a;
        rem_q     <= '0;
        cnt       <= CW'(WIDTH - 1);
        q_neg     <= (bus.AluControlPort[1:0] == 2'b00) & (bus.rs1_val[WIDTH-1] ^ bus.rs2_val[WIDTH-1]);
        r_neg     <= (bus.AluControlPort[1:0] == 2'b10) & bus.rs1_val[WIDTH-1];
        if (div_zero) begin
          bus.div_result       <= bus.AluControlPort[1] ? bus.rs1_val : '1;
          bus.div_result_valid <= 1'b1;
          bus.div_rd           <= bus.rd_in;
        end else if (sgn_ovf) begin
          bus.div_result       <= bus.AluControlPort[1] ? '0 : bus.rs1_val;
          bus.div_result_valid <= 1'b1;
          bus.div_rd           <= bus.rd_in;
        end
      end else if (state == CALC && !bus.flush) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        if (cnt == '0) begin
          bus.div_result       <= op_q[1] ? rem_fix : quo_fix;
          bus.div_result_valid <= 1'b1;
          bus.div_rd           <= rd_q;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed vector bench for div_sequencer
module tb_div_sequencer;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stalls;
  } vec_t;

  localparam logic [4:0] OP_DIV  = 5'b10100;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b10110;
  localparam logic [4:0] OP_REMU = 5'b10111;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int stalls, output bit ok);
    @(negedge clk);
    bus.AluControlPort = alu;
    bus.rs1_val        = a;
    bus.rs2_val        = b;
    bus.rd_in          = rd;
    bus.op_valid       = 1'b1;
    bus.flush          = 1'b0;
    #1;
    stalls = 0;
    ok     = 1'b0;
    res    = '0;
    rdo    = '0;
    for (int c = 0; c < 60; c++) begin
      if (bus.div_result_valid) begin
        ok  = 1'b1;
        res = bus.div_result;
        rdo = bus.div_rd;
        if (bus.DivStalled) stalls += 100;
        break;
      end
      if (bus.DivStalled) stalls++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [4:0]  rdo;
    int          stalls;
    bit          ok;
    int          strobes;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[6]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1};
    vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[11] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};
    vecs[12] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[13] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[14] = '{OP_DIVU, 32'd3,          32'd10,         32'd0,          33};

    reset              = 1'b1;
    bus.AluControlPort = '0;
    bus.op_valid       = 1'b0;
    bus.flush          = 1'b0;
    bus.rs1_val        = '0;
    bus.rs2_val        = '0;
    bus.rd_in          = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_valid",  {31'd0, bus.div_result_valid}, 32'd0);
    check("reset_result", bus.div_result, 32'd0);
    check("reset_rd",     {27'd0, bus.div_rd}, 32'd0);
    check("reset_stall",  {31'd0, bus.DivStalled}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Non-divide encodings must never stall or strobe.
    for (int v = 0; v < 32; v++) begin
      logic [4:0] code;
      code = 5'(v);
      if (code[4] & code[2]) continue;
      @(negedge clk);
      bus.AluControlPort = code;
      bus.op_valid       = 1'b1;
      bus.rs1_val        = 32'd100;
      bus.rs2_val        = 32'd7;
      #1;
      check($sformatf("nondiv_stall_%0d", v), {31'd0, bus.DivStalled}, 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("nondiv_strobe_%0d", v), {31'd0, bus.div_result_valid}, 32'd0);
    end

    @(negedge clk);
    bus.AluControlPort = OP_DIVU;
    bus.op_valid       = 1'b0;
    #1;
    check("bubble_stall", {31'd0, bus.DivStalled}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].alu, vecs[i].a, vecs[i].b, 5'(i + 1), res, rdo, stalls, ok);
      check($sformatf("v%0d_done", i), {31'd0, ok}, 32'd1);
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      check($sformatf("v%0d_rd", i), {27'd0, rdo}, 32'(i + 1));
      check($sformatf("v%0d_stalls", i), 32'(stalls), 32'(vecs[i].stalls));
    end

    // Flush in the start cycle wins over start.
    @(negedge clk);
    bus.AluControlPort = OP_DIV;
    bus.rs1_val        = 32'd10;
    bus.rs2_val        = 32'd2;
    bus.op_valid       = 1'b1;
    bus.flush          = 1'b1;
    #1;
    check("flush_start_stall", {31'd0, bus.DivStalled}, 32'd0);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    check("flush_start_strobe", {31'd0, bus.div_result_valid}, 32'd0);
    check("flush_start_idle",   {31'd0, bus.DivStalled}, 32'd0);

    // Flush in the tenth CALC cycle.
    @(negedge clk);
    bus.AluControlPort = OP_DIVU;
    bus.rs1_val        = 32'd1000;
    bus.rs2_val        = 32'd3;
    bus.rd_in          = 5'd20;
    bus.op_valid       = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("calc10_stall", {31'd0, bus.DivStalled}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    check("flush_calc_stall",  {31'd0, bus.DivStalled}, 32'd0);
    check("flush_calc_strobe", {31'd0, bus.div_result_valid}, 32'd0);
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.div_result_valid) strobes++;
    end
    check("flush_no_strobe", 32'(strobes), 32'd0);

    run_op(OP_DIVU, 32'd9, 32'd3, 5'd11, res, rdo, stalls, ok);
    check("after_flush_done",   {31'd0, ok}, 32'd1);
    check("after_flush_result", res, 32'd3);
    check("after_flush_rd",     {27'd0, rdo}, 32'd11);
    check("after_flush_stalls", 32'(stalls), 32'd33);

    // Reset pulsed in the middle of CALC.
    @(negedge clk);
    bus.AluControlPort = OP_DIVU;
    bus.rs1_val        = 32'd50;
    bus.rs2_val        = 32'd5;
    bus.rd_in          = 5'd9;
    bus.op_valid       = 1'b1;
    repeat (5) @(negedge clk);
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_calc_valid",  {31'd0, bus.div_result_valid}, 32'd0);
    check("rst_calc_result", bus.div_result, 32'd0);
    check("rst_calc_rd",     {27'd0, bus.div_rd}, 32'd0);
    check("rst_calc_stall",  {31'd0, bus.DivStalled}, 32'd0);
    reset   = 1'b0;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.div_result_valid) strobes++;
    end
    check("rst_no_strobe", 32'(strobes), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
